// File: rtl/manchester_pkg.sv
// manchester_pkg: shared FSM state encoding, mid-bit timing window helpers and polarity codes
package manchester_pkg;

    typedef enum logic [1:0] {HUNT, ACQ, SEARCH, DATA} state_e;

    localparam bit POL_IEEE   = 1'b0;
    localparam bit POL_THOMAS = 1'b1;

    function automatic int win_lo(input int osr);
        return (3 * osr) / 4;
    endfunction

    function automatic int win_hi(input int osr);
        return (5 * osr) / 4;
    endfunction

endpackage

// File: rtl/man_edge_sync.sv
// man_edge_sync: two-flop synchroniser for the raw line plus a change-detect register
module man_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic edge_o
);
    logic s1_q, s2_q, lvl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            s1_q  <= din_i;
            s2_q  <= s1_q;
            lvl_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign edge_o  = s2_q ^ lvl_q;

endmodule

// File: rtl/manchester_rx_framer.sv
// manchester_rx_framer: oversampled Manchester bit recovery, sync-word search and word deserialisation
// cnt_q holds the number of clk cycles elapsed since the last accepted edge (1 in the cycle after it).
module manchester_rx_framer
    import manchester_pkg::*;
#(
    parameter int                OSR       = 16,
    parameter int                WORD_W    = 8,
    parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'('hD5),
    parameter bit                POLARITY  = POL_IEEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              Man_data,
    output logic              bit_stb,
    output logic              bit_out,
    output logic              locked,
    output logic              sync_det,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_end,
    output logic              err
);
    localparam int LO = win_lo(OSR);
    localparam int HI = win_hi(OSR);
    localparam int CW = $clog2(HI + 2);
    localparam int BW = $clog2(WORD_W);
    localparam logic [CW-1:0] LO_C   = CW'(LO);
    localparam logic [CW-1:0] HI_C   = CW'(HI);
    localparam logic [CW-1:0] SAT_C  = CW'(HI + 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [BW-1:0] LAST_C = BW'(WORD_W - 1);

    logic level, edge_det;

    man_edge_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .din_i   (Man_data),
        .level_o (level),
        .edge_o  (edge_det)
    );

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] sr_q, sr_d, dout_q, dout_d, shifted;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              stb_q, stb_d, bit_q, bit_d, sync_q, sync_d;
    logic              wdone_q, wdone_d, dv_q, dv_d, fend_q, fend_d, err_q, err_d;
    logic              rx_bit, in_win, tout, mid;

    assign rx_bit  = level ^ POLARITY;
    assign in_win  = (cnt_q >= LO_C) && (cnt_q <= HI_C);
    assign tout    = cnt_q > HI_C;
    assign mid     = edge_det && in_win;
    assign shifted = {sr_q[WORD_W-2:0], rx_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            sr_q    <= '0;
            bcnt_q  <= '0;
            dout_q  <= '0;
            stb_q   <= 1'b0;
            bit_q   <= 1'b0;
            sync_q  <= 1'b0;
            wdone_q <= 1'b0;
            dv_q    <= 1'b0;
            fend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            dout_q  <= dout_d;
            stb_q   <= stb_d;
            bit_q   <= bit_d;
            sync_q  <= sync_d;
            wdone_q <= wdone_d;
            dv_q    <= dv_d;
            fend_q  <= fend_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == SAT_C) ? cnt_q : cnt_q + 1'b1;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        stb_d   = 1'b0;
        bit_d   = bit_q;
        sync_d  = 1'b0;
        wdone_d = 1'b0;
        fend_d  = 1'b0;
        err_d   = 1'b0;
        dv_d    = wdone_q;
        dout_d  = wdone_q ? sr_q : dout_q;
        if (!en) begin
            state_d = HUNT;
            cnt_d   = '0;
            sr_d    = '0;
            bcnt_d  = '0;
            dv_d    = 1'b0;
            dout_d  = dout_q;
        end else begin
            case (state_q)
                HUNT: begin
                    if (edge_det) begin
                        cnt_d   = ONE_C;
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (tout) begin
                        state_d = HUNT;
                    end else if (edge_det) begin
                        cnt_d = ONE_C;
                        if (in_win) begin
                            stb_d   = 1'b1;
                            bit_d   = rx_bit;
                            sr_d    = shifted;
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    // Losing the line mid-word is an error; losing it on a word boundary ends the frame.
                    if (tout) begin
                        state_d = HUNT;
                        sr_d    = '0;
                        bcnt_d  = '0;
                        fend_d  = (state_q == DATA) && (bcnt_q == '0);
                        err_d   = (state_q == DATA) && (bcnt_q != '0);
                    end else if (mid) begin
                        cnt_d = ONE_C;
                        stb_d = 1'b1;
                        bit_d = rx_bit;
                        sr_d  = shifted;
                        if (state_q == SEARCH) begin
                            if (shifted == SYNC_WORD) begin
                                sync_d  = 1'b1;
                                bcnt_d  = '0;
                                state_d = DATA;
                            end
                        end else begin
                            wdone_d = bcnt_q == LAST_C;
                            bcnt_d  = (bcnt_q == LAST_C) ? '0 : bcnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bit_stb    = stb_q;
    assign bit_out    = bit_q;
    assign locked     = (state_q == SEARCH) || (state_q == DATA);
    assign sync_det   = sync_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign frame_end  = fend_q;
    assign err        = err_q;

endmodule
